dmem_arbiter: RTL and testbench

Two-port access controller sitting in front of the byte-addressed data memory. It arbitrates round-robin between the core load/store unit (port 0) and the debug/DMA port (port 1), and checks type, alignment and range. It drives the memory's edge-sensitive read/write enables as clean single-cycle strobes, with address, data and type held stable around each strobe. It returns read data or an error on a per-port response handshake.

---
 rtl/dmem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-port access controller in front of the byte-addressed data memory.
// Port 0 (core load/store unit) and port 1 (debug/DMA) are arbitrated
// round-robin. Each accepted request is checked for a legal type, natural
// alignment and address range. A legal request is run as a clean memory cycle:
// the bus is set up, one single-cycle strobe is issued, the bus is held one
// more cycle, and the read data is captured. The result (or an error for a
// rejected request) is returned on the owning port's response handshake.
// Only one transaction is outstanding at a time.
//
// Ports
//   clk, rstn                  clock (rising edge), asynchronous active-low reset
//   pN_req_valid/ready         request handshake, N = 0, 1
//   pN_req_addr/wdata/we/type  byte address, store data, 1 = store, access type
//                              (000 byte, 100 ubyte, 001 half, 110 uhalf, 010 word)
//   pN_resp_valid/ready        response handshake
//   pN_resp_rdata              load result; 0 for stores and errors
//   pN_resp_err                request rejected with no memory access
//   mem_address/write_data/type  memory bus, changes only when a legal request
//                              is accepted
//   mem_write_enable/read_enable single-cycle strobes
//   mem_read_data              from memory, valid the cycle after the read strobe
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        p0_req_valid,
    output logic        p0_req_ready,
    input  logic [31:0] p0_req_addr,
    input  logic [31:0] p0_req_wdata,
    input  logic        p0_req_we,
    input  logic [2:0]  p0_req_type,
    output logic        p0_resp_valid,
    input  logic        p0_resp_ready,
    output logic [31:0] p0_resp_rdata,
    output logic        p0_resp_err,

    input  logic        p1_req_valid,
    output logic        p1_req_ready,
    input  logic [31:0] p1_req_addr,
    input  logic [31:0] p1_req_wdata,
    input  logic        p1_req_we,
    input  logic [2:0]  p1_req_type,
    output logic        p1_resp_valid,
    input  logic        p1_resp_ready,
    output logic [31:0] p1_resp_rdata,
    output logic        p1_resp_err,

    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [2:0]  mem_type,
    output logic        mem_write_enable,
    output logic        mem_read_enable,
    input  logic [31:0] mem_read_data
);

    localparam logic [2:0] TYPE_B  = 3'b000;
    localparam logic [2:0] TYPE_BU = 3'b100;
    localparam logic [2:0] TYPE_H  = 3'b001;
    localparam logic [2:0] TYPE_HU = 3'b110;
    localparam logic [2:0] TYPE_W  = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        CAPTURE,
        RESP
    } state_t;

    // ---------------------------------------------------------------------
    // Per-port request/response signals gathered into arrays so the port
    // logic can be written once.
    // ---------------------------------------------------------------------
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [1:0]  resp_ready;
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [2:0]  req_type  [2];
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_err;
    logic [31:0] resp_rdata [2];

    assign req_valid    = {p1_req_valid, p0_req_valid};
    assign req_we       = {p1_req_we, p0_req_we};
    assign resp_ready   = {p1_resp_ready, p0_resp_ready};
    assign req_addr[0]  = p0_req_addr;
    assign req_addr[1]  = p1_req_addr;
    assign req_wdata[0] = p0_req_wdata;
    assign req_wdata[1] = p1_req_wdata;
    assign req_type[0]  = p0_req_type;
    assign req_type[1]  = p1_req_type;

    assign p0_req_ready  = req_ready[0];
    assign p1_req_ready  = req_ready[1];
    assign p0_resp_valid = resp_valid[0];
    assign p1_resp_valid = resp_valid[1];
    assign p0_resp_err   = resp_err[0];
    assign p1_resp_err   = resp_err[1];
    assign p0_resp_rdata = resp_rdata[0];
    assign p1_resp_rdata = resp_rdata[1];

    // ---------------------------------------------------------------------
    // State. The memory bus registers double as the request latch for
    // address, store data and type: they are loaded exactly once, when a
    // legal request leaves IDLE, and otherwise hold their last values.
    // ---------------------------------------------------------------------
    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        port_q, port_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]  mem_type_q, mem_type_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_re_q, mem_re_d;

    assign mem_address      = mem_address_q;
    assign mem_write_data   = mem_wdata_q;
    assign mem_type         = mem_type_q;
    assign mem_write_enable = mem_we_q;
    assign mem_read_enable  = mem_re_q;

    // ---------------------------------------------------------------------
    // Round-robin grant: a lone requester wins; on a tie the port that did
    // not win last time goes next.
    // ---------------------------------------------------------------------
    logic grant_valid;
    logic grant_port;

    assign grant_valid = |req_valid;
    assign grant_port  = (&req_valid) ? ~last_grant_q : req_valid[1];

    // Legal type for the direction, natural alignment, and the last byte
    // touched inside the memory. The end address is formed in 33 bits so a
    // request near 0xFFFFFFFF cannot wrap back into range.
    function automatic logic req_legal(input logic we, input logic [2:0] t,
                                       input logic [31:0] a);
        logic        kind_ok;
        logic        align_ok;
        logic [32:0] size;
        logic [32:0] last_byte;
        kind_ok  = 1'b0;
        align_ok = 1'b1;
        size     = 33'd1;
        case (t)
            TYPE_B:  begin kind_ok = 1'b1; size = 33'd1; end
            TYPE_BU: begin kind_ok = ~we;  size = 33'd1; end
            TYPE_H:  begin kind_ok = 1'b1; size = 33'd2; align_ok = ~a[0]; end
            TYPE_HU: begin kind_ok = ~we;  size = 33'd2; align_ok = ~a[0]; end
            TYPE_W:  begin kind_ok = 1'b1; size = 33'd4; align_ok = (a[1:0] == 2'b00); end
            default: kind_ok = 1'b0;
        endcase
        last_byte = {1'b0, a} + size - 33'd1;
        return kind_ok && align_ok && (last_byte <= 33'(MEM_BYTES - 1));
    endfunction

    // The memory returns the addressed bytes in the low lanes; the upper
    // lanes are not trusted, so the load result is rebuilt here from the type.
    function automatic logic [31:0] load_extend(input logic [31:0] d,
                                                input logic [2:0] t);
        logic [31:0] r;
        case (t)
            TYPE_B:  r = {{24{d[7]}}, d[7:0]};
            TYPE_BU: r = {24'h000000, d[7:0]};
            TYPE_H:  r = {{16{d[15]}}, d[15:0]};
            TYPE_HU: r = {16'h0000, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        port_d        = port_q;
        we_d          = we_q;
        err_d         = err_q;
        rdata_d       = rdata_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        mem_type_d    = mem_type_q;
        // Strobes are only ever raised for the single cycle after SETUP.
        mem_we_d      = 1'b0;
        mem_re_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    port_d       = grant_port;
                    last_grant_d = grant_port;
                    we_d         = req_we[grant_port];
                    rdata_d      = '0;
                    if (req_legal(req_we[grant_port], req_type[grant_port],
                                  req_addr[grant_port])) begin
                        err_d         = 1'b0;
                        mem_address_d = req_addr[grant_port];
                        mem_wdata_d   = req_wdata[grant_port];
                        mem_type_d    = req_type[grant_port];
                        state_d       = SETUP;
                    end else begin
                        // Rejected: bus untouched, answer straight away.
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            SETUP: begin
                mem_we_d = we_q;
                mem_re_d = ~we_q;
                state_d  = STROBE;
            end
            STROBE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                if (!we_q) begin
                    rdata_d = load_extend(mem_read_data, mem_type_q);
                end
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready[port_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State registers. Reset is asynchronous so an in-flight strobe drops
    // the moment rstn falls.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            port_q        <= 1'b0;
            we_q          <= 1'b0;
            err_q         <= 1'b0;
            rdata_q       <= '0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            mem_type_q    <= '0;
            mem_we_q      <= 1'b0;
            mem_re_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            port_q        <= port_d;
            we_q          <= we_d;
            err_q         <= err_d;
            rdata_q       <= rdata_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_type_q    <= mem_type_d;
            mem_we_q      <= mem_we_d;
            mem_re_q      <= mem_re_d;
        end
    end

    // ---------------------------------------------------------------------
    // Per-port handshake outputs. Ready is offered only in IDLE and only to
    // the granted port, so the other port can never slip in while a
    // transaction is outstanding.
    // ---------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign req_ready[gi]  = (state_q == IDLE) && grant_valid &&
                                    (grant_port == 1'(gi));
            assign resp_valid[gi] = (state_q == RESP) && (port_q == 1'(gi));
            assign resp_err[gi]   = resp_valid[gi] & err_q;
            assign resp_rdata[gi] = resp_valid[gi] ? rdata_q : '0;
        end
    endgenerate

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int MEM_BYTES = 1024;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [1:0]  resp_ready;
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [2:0]  req_type  [2];

    logic        p0_req_ready, p1_req_ready;
    logic        p0_resp_valid, p1_resp_valid;
    logic        p0_resp_err, p1_resp_err;
    logic [31:0] p0_resp_rdata, p1_resp_rdata;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic [2:0]  mem_type;
    logic        mem_write_enable, mem_read_enable;

    dmem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .p0_req_valid     (req_valid[0]),
        .p0_req_ready     (p0_req_ready),
        .p0_req_addr      (req_addr[0]),
        .p0_req_wdata     (req_wdata[0]),
        .p0_req_we        (req_we[0]),
        .p0_req_type      (req_type[0]),
        .p0_resp_valid    (p0_resp_valid),
        .p0_resp_ready    (resp_ready[0]),
        .p0_resp_rdata    (p0_resp_rdata),
        .p0_resp_err      (p0_resp_err),
        .p1_req_valid     (req_valid[1]),
        .p1_req_ready     (p1_req_ready),
        .p1_req_addr      (req_addr[1]),
        .p1_req_wdata     (req_wdata[1]),
        .p1_req_we        (req_we[1]),
        .p1_req_type      (req_type[1]),
        .p1_resp_valid    (p1_resp_valid),
        .p1_resp_ready    (resp_ready[1]),
        .p1_resp_rdata    (p1_resp_rdata),
        .p1_resp_err      (p1_resp_err),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_type         (mem_type),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_read_data    (mem_read_data)
    );

    // ---------------- memory model: byte array, little-endian ------------
    // Reads return the four bytes starting at the address unmasked, so the
    // DUT must select and extend the addressed lanes itself.
    logic [7:0]  mem [MEM_BYTES];
    logic        mem_init = 1'b0;
    logic [31:0] mrd;
    assign mem_read_data = mrd;

    function automatic logic [31:0] mem_rd(input logic [9:0] a);
        return {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
    endfunction

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;
            mem_init <= 1'b1;
            mrd      <= 32'h0;
        end else begin
            if (mem_write_enable) begin
                case (mem_type)
                    3'b000: mem[mem_address[9:0]] <= mem_write_data[7:0];
                    3'b001: begin
                        mem[mem_address[9:0]]         <= mem_write_data[7:0];
                        mem[mem_address[9:0] + 10'd1] <= mem_write_data[15:8];
                    end
                    3'b010: begin
                        mem[mem_address[9:0]]         <= mem_write_data[7:0];
                        mem[mem_address[9:0] + 10'd1] <= mem_write_data[15:8];
                        mem[mem_address[9:0] + 10'd2] <= mem_write_data[23:16];
                        mem[mem_address[9:0] + 10'd3] <= mem_write_data[31:24];
                    end
                    default: ;
                endcase
            end
            if (mem_read_enable) mrd <= mem_rd(mem_address[9:0]);
        end
    end

    // ---------------- bus protocol monitor ------------------------------
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          mon_err = 0;
    logic        prev_we = 1'b0, prev_re = 1'b0;
    logic [66:0] prev_bus = '0;

    always @(posedge clk) begin
        if (mem_write_enable) wr_cnt <= wr_cnt + 1;
        if (mem_read_enable)  rd_cnt <= rd_cnt + 1;
        if ((mem_write_enable && mem_read_enable) ||
            (mem_write_enable && prev_we) || (mem_read_enable && prev_re) ||
            ((mem_write_enable || mem_read_enable || prev_we || prev_re) &&
             ({mem_address, mem_write_data, mem_type} != prev_bus)))
            mon_err <= mon_err + 1;
        prev_we  <= mem_write_enable;
        prev_re  <= mem_read_enable;
        prev_bus <= {mem_address, mem_write_data, mem_type};
    end

    // ---------------- checking helpers ----------------------------------
    int checks = 0;
    int failures = 0;
    int last_port = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input int p);
        return (p == 1) ? p1_req_ready : p0_req_ready;
    endfunction
    function automatic logic rv(input int p);
        return (p == 1) ? p1_resp_valid : p0_resp_valid;
    endfunction
    function automatic logic rerr(input int p);
        return (p == 1) ? p1_resp_err : p0_resp_err;
    endfunction
    function automatic logic [31:0] rdat(input int p);
        return (p == 1) ? p1_resp_rdata : p0_resp_rdata;
    endfunction

    task automatic set_req(input int p, input logic we, input logic [2:0] t,
                           input logic [31:0] a, input logic [31:0] wd);
        req_valid[p] = 1'b1;
        req_we[p]    = we;
        req_type[p]  = t;
        req_addr[p]  = a;
        req_wdata[p] = wd;
    endtask

    task automatic wait_ready(input int p, input string name, output logic ok);
        int cnt = 0;
        while (!rdy(p) && cnt < 20) begin
            @(posedge clk); #1; cnt++;
        end
        ok = rdy(p);
        if (!ok) begin
            checks++; failures++;
            $display("FAIL %s_ready: actual=timeout required=ready within 20 cycles", name);
        end
    endtask

    // One full transaction; 'alt' is a second acceptable read value.
    task automatic txn(input int p, input logic we, input logic [2:0] t,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic exp_err, input logic [31:0] exp_rd,
                       input logic [31:0] alt_rd, input string name);
        logic ok;
        logic addr_ok;
        int   lat, wr0, rd0, ewr, erd;
        set_req(p, we, t, a, wd);
        wait_ready(p, name, ok);
        if (!ok) begin
            req_valid[p] = 1'b0;
            return;
        end
        @(posedge clk);               // handshake edge T
        wr0 = wr_cnt; rd0 = rd_cnt;
        #1; req_valid[p] = 1'b0;
        lat = 1; addr_ok = 1'b1;
        while (!rv(p) && lat < 10) begin
            if (mem_address !== a) addr_ok = 1'b0;
            @(posedge clk); #1; lat++;
        end
        ewr = (!exp_err && we)  ? 1 : 0;
        erd = (!exp_err && !we) ? 1 : 0;
        chk({name, "_lat"}, 32'(lat), exp_err ? 32'd1 : 32'd4);
        chk({name, "_err"}, {31'b0, rerr(p)}, {31'b0, exp_err});
        checks++;
        if (!(rdat(p) === exp_rd || rdat(p) === alt_rd)) begin
            failures++;
            $display("FAIL %s_rdata: actual=0x%08h required=0x%08h", name, rdat(p), exp_rd);
        end
        chk({name, "_strobes"}, 32'((wr_cnt - wr0) * 16 + (rd_cnt - rd0)), 32'(ewr * 16 + erd));
        chk({name, "_other_idle"}, {31'b0, rv(1 - p)}, 32'd0);
        if (!exp_err) chk({name, "_bus_held"}, {31'b0, addr_ok}, 32'd1);
        $display("txn %s port=%0d we=%0b type=%03b addr=0x%08h rdata=0x%08h err=%0b lat=%0d",
                 name, p, we, t, a, rdat(p), rerr(p), lat);
        last_port = p;
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #500000;
        $display("FAIL watchdog: actual=no finish required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ok, stable;
        logic [31:0] held;
        logic [31:0] t_addr [2][3];
        logic [31:0] t_exp  [2][3];
        int          idx [2];
        int          exp_p, gp, lat;

        req_valid  = 2'b00;
        req_we     = 2'b00;
        resp_ready = 2'b11;
        for (int p = 0; p < 2; p++) begin
            req_addr[p] = '0; req_wdata[p] = '0; req_type[p] = '0;
        end

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("reset_bus_addr", mem_address, 32'h0);
        chk("reset_bus_misc", {mem_write_data[28:0], mem_type}, 32'h0);
        chk("reset_flags", {26'b0, p0_req_ready, p1_req_ready, p0_resp_valid, p1_resp_valid,
                            mem_write_enable, mem_read_enable}, 32'h0);
        chk("reset_resp", p0_resp_rdata | p1_resp_rdata | {30'b0, p0_resp_err, p1_resp_err}, 32'h0);
        rstn = 1'b1;

        // ---------------- table-driven vectors ----------------
        vecs.push_back('{0, 1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0});
        vecs.push_back('{0, 1'b0, 3'b010, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF});
        vecs.push_back('{1, 1'b1, 3'b000, 32'h0000_0020, 32'h1234_5680, 1'b0, 32'h0});
        vecs.push_back('{1, 1'b0, 3'b000, 32'h0000_0020, 32'h0,         1'b0, 32'hFFFF_FF80});
        vecs.push_back('{1, 1'b0, 3'b100, 32'h0000_0020, 32'h0,         1'b0, 32'h0000_0080});
        vecs.push_back('{0, 1'b1, 3'b001, 32'h0000_0030, 32'hABCD_8001, 1'b0, 32'h0});
        vecs.push_back('{1, 1'b0, 3'b001, 32'h0000_0030, 32'h0,         1'b0, 32'hFFFF_8001});
        vecs.push_back('{1, 1'b0, 3'b110, 32'h0000_0030, 32'h0,         1'b0, 32'h0000_8001});
        vecs.push_back('{0, 1'b0, 3'b001, 32'h0000_0003, 32'h0,         1'b1, 32'h0});
        vecs.push_back('{0, 1'b0, 3'b010, 32'h0000_0002, 32'h0,         1'b1, 32'h0});
        vecs.push_back('{1, 1'b0, 3'b010, 32'(MEM_BYTES - 2), 32'h0,    1'b1, 32'h0});
        vecs.push_back('{0, 1'b1, 3'b100, 32'h0000_0040, 32'h5555_5555, 1'b1, 32'h0});
        vecs.push_back('{1, 1'b0, 3'b000, 32'hFFFF_FFFF, 32'h0,         1'b1, 32'h0});
        vecs.push_back('{0, 1'b0, 3'b011, 32'h0000_0000, 32'h0,         1'b1, 32'h0});
        vecs.push_back('{1, 1'b1, 3'b110, 32'h0000_0030, 32'h0000_1111, 1'b1, 32'h0});
        vecs.push_back('{0, 1'b1, 3'b000, 32'(MEM_BYTES - 1), 32'h0000_005A, 1'b0, 32'h0});
        vecs.push_back('{1, 1'b0, 3'b100, 32'(MEM_BYTES - 1), 32'h0,    1'b0, 32'h0000_005A});
        vecs.push_back('{0, 1'b1, 3'b010, 32'(MEM_BYTES - 4), 32'h0102_0304, 1'b0, 32'h0});
        vecs.push_back('{1, 1'b0, 3'b010, 32'(MEM_BYTES - 4), 32'h0,    1'b0, 32'h0102_0304});
        vecs.push_back('{1, 1'b0, 3'b000, 32'(MEM_BYTES - 1), 32'h0,    1'b0, 32'h0000_0001});
        vecs.push_back('{0, 1'b0, 3'b000, 32'(MEM_BYTES),     32'h0,    1'b1, 32'h0});
        vecs.push_back('{0, 1'b1, 3'b010, 32'h0000_0040, 32'hAAAA_AAAA, 1'b0, 32'h0});
        for (int i = 0; i < 3; i++) begin
            t_addr[0][i] = 32'h100 + 32'(4 * i); t_exp[0][i] = 32'hA000_0000 + 32'(i);
            t_addr[1][i] = 32'h200 + 32'(4 * i); t_exp[1][i] = 32'hB000_0000 + 32'(i);
            vecs.push_back('{0, 1'b1, 3'b010, t_addr[0][i], t_exp[0][i], 1'b0, 32'h0});
            vecs.push_back('{1, 1'b1, 3'b010, t_addr[1][i], t_exp[1][i], 1'b0, 32'h0});
        end

        for (int i = 0; i < vecs.size(); i++) begin
            txn(vecs[i].port, vecs[i].we, vecs[i].typ, vecs[i].addr, vecs[i].wdata,
                vecs[i].err, vecs[i].rdata, vecs[i].rdata, $sformatf("vec%0d", i));
        end

        // ---------------- both ports valid: round-robin ----------------
        idx[0] = 0; idx[1] = 0;
        set_req(0, 1'b0, 3'b010, t_addr[0][0], 32'h0);
        set_req(1, 1'b0, 3'b010, t_addr[1][0], 32'h0);
        exp_p = 1 - last_port;
        for (int k = 0; k < 6; k++) begin
            wait_ready(exp_p, "rr", ok);
            if (!ok) break;
            gp = rdy(1) ? 1 : 0;
            chk("rr_grant", 32'(gp), 32'(exp_p));
            chk("rr_single_ready", {31'b0, p0_req_ready & p1_req_ready}, 32'd0);
            @(posedge clk); #1;
            idx[gp]++;
            if (idx[gp] < 3) req_addr[gp] = t_addr[gp][idx[gp]];
            else             req_valid[gp] = 1'b0;
            lat = 1;
            while (!rv(gp) && lat < 10) begin
                @(posedge clk); #1; lat++;
            end
            chk("rr_lat", 32'(lat), 32'd4);
            chk("rr_rdata", rdat(gp), t_exp[gp][idx[gp] - 1]);
            chk("rr_other_idle", {31'b0, rv(1 - gp)}, 32'd0);
            $display("txn rr%0d port=%0d rdata=0x%08h lat=%0d", k, gp, rdat(gp), lat);
            last_port = gp;
            exp_p = 1 - gp;
        end
        req_valid = 2'b00;

        // ---------------- response backpressure ----------------
        resp_ready[0] = 1'b0;
        set_req(0, 1'b0, 3'b010, 32'h10, 32'h0);
        wait_ready(0, "bp", ok);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        set_req(1, 1'b0, 3'b010, t_addr[0][1], 32'h0);
        lat = 1;
        while (!rv(0) && lat < 10) begin
            @(posedge clk); #1; lat++;
        end
        chk("bp_rdata", p0_resp_rdata, 32'hDEAD_BEEF);
        held = p0_resp_rdata;
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (!p0_resp_valid || p0_resp_rdata !== held || p1_req_ready) stable = 1'b0;
        end
        chk("bp_stable", {31'b0, stable}, 32'd1);
        resp_ready[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_released", {30'b0, p0_resp_valid, p1_req_ready}, 32'd1);
        $display("txn bp port=0 rdata=0x%08h held=10", held);
        txn(1, 1'b0, 3'b010, t_addr[0][1], 32'h0, 1'b0, t_exp[0][1], t_exp[0][1], "bp_p1");

        // ---------------- reset during a store strobe ----------------
        set_req(0, 1'b1, 3'b010, 32'h40, 32'h1122_3344);
        wait_ready(0, "rst", ok);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        chk("rst_strobe_seen", {31'b0, mem_write_enable}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("rst_enables", {30'b0, mem_write_enable, mem_read_enable}, 32'd0);
        chk("rst_addr", mem_address, 32'h0);
        chk("rst_wdata", mem_write_data, 32'h0);
        chk("rst_flags", {26'b0, mem_type, p0_resp_valid, p1_resp_valid, p0_resp_err}, 32'd0);
        chk("rst_rdata", p0_resp_rdata | p1_resp_rdata, 32'h0);
        $display("txn rst port=0 store aborted addr=0x00000040");
        repeat (2) @(posedge clk);
        #1; rstn = 1'b1;
        // last_grant is back to 1, so port 0 must win this tie.
        set_req(1, 1'b0, 3'b010, t_addr[1][1], 32'h0);
        set_req(0, 1'b0, 3'b010, 32'h40, 32'h0);
        #1;
        chk("rst_tie_p0", {30'b0, p0_req_ready, p1_req_ready}, 32'd2);
        txn(0, 1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 32'hAAAA_AAAA, 32'h1122_3344, "rst_reload");
        chk("rst_no_x", {31'b0, $isunknown({p0_resp_rdata, p1_resp_rdata, mem_address,
                                            mem_write_data, mem_type, p0_resp_err})}, 32'd0);
        txn(1, 1'b0, 3'b010, t_addr[1][1], 32'h0, 1'b0, t_exp[1][1], t_exp[1][1], "rst_p1");

        repeat (2) @(posedge clk);
        #1;
        chk("bus_protocol", 32'(mon_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
